// File: rtl/queue_dispatcher.sv
// Pops one entry from a granted request queue and issues it on a valid/ready master port,
// returning a consumed pulse and keeping per-queue served counters, a watchdog and sticky error flags.
module queue_dispatcher #(
  parameter int unsigned NUMBER_OF_QUEUES = 4,
  parameter int unsigned DATA_WIDTH       = 64,
  parameter int unsigned REGISTER_SIZE    = 32,
  parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         enable,
  input  logic [$clog2(NUMBER_OF_QUEUES)-1:0]          id,
  input  logic [NUMBER_OF_QUEUES-1:0]                  empty,
  input  logic [NUMBER_OF_QUEUES*DATA_WIDTH-1:0]       queue_data,
  output logic [NUMBER_OF_QUEUES-1:0]                  pop,
  output logic                                         m_valid,
  input  logic                                         m_ready,
  output logic [DATA_WIDTH-1:0]                        m_data,
  output logic [$clog2(NUMBER_OF_QUEUES)-1:0]          m_id,
  output logic                                         consumed,
  output logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0]    served,
  output logic                                         timeout,
  output logic                                         spurious,
  input  logic                                         clear_flags
);

  localparam int unsigned ID_W = $clog2(NUMBER_OF_QUEUES);
  localparam logic [REGISTER_SIZE-1:0] TIMEOUT_LIM = REGISTER_SIZE'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]    m_data_q, m_data_d;
  logic [ID_W-1:0]          m_id_q, m_id_d;
  logic                     consumed_q, consumed_d;
  logic [REGISTER_SIZE-1:0] served_q [NUMBER_OF_QUEUES];
  logic [REGISTER_SIZE-1:0] served_d [NUMBER_OF_QUEUES];
  logic [REGISTER_SIZE-1:0] wdog_q, wdog_d;
  logic                     timeout_q, timeout_d;
  logic                     spurious_q, spurious_d;

  logic                     head_empty;
  logic [DATA_WIDTH-1:0]    head_data;
  logic                     grant_ok;
  logic                     timeout_set;

  // Head-of-queue select; an id matching no queue reads as empty.
  always_comb begin
    head_empty = 1'b1;
    head_data  = '0;
    for (int q = 0; q < int'(NUMBER_OF_QUEUES); q++) begin
      if (id == ID_W'(q)) begin
        head_empty = empty[q];
        head_data  = queue_data[q*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign grant_ok = enable && (state_q == IDLE) && !head_empty;

  always_comb begin
    pop = '0;
    for (int q = 0; q < int'(NUMBER_OF_QUEUES); q++) begin
      pop[q] = grant_ok && (id == ID_W'(q));
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_id_d      = m_id_q;
    consumed_d  = 1'b0;
    served_d    = served_q;
    wdog_d      = wdog_q;
    timeout_set = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_ok) begin
          m_data_d  = head_data;
          m_id_d    = id;
          m_valid_d = 1'b1;
          wdog_d    = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (m_ready) begin
          m_valid_d  = 1'b0;
          consumed_d = 1'b1;
          state_d    = DONE;
        end else if (wdog_q != TIMEOUT_LIM) begin
          wdog_d = wdog_q + REGISTER_SIZE'(1);
          if ((wdog_q + REGISTER_SIZE'(1)) == TIMEOUT_LIM) begin
            timeout_set = 1'b1;
          end
        end
      end
      DONE: begin
        for (int q = 0; q < int'(NUMBER_OF_QUEUES); q++) begin
          if (m_id_q == ID_W'(q)) begin
            served_d[q] = served_q[q] + REGISTER_SIZE'(1);
          end
        end
        state_d = IDLE;
      end
      default: begin
        m_valid_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    // A new flag event overrides a simultaneous clear.
    timeout_d  = clear_flags ? 1'b0 : timeout_q;
    spurious_d = clear_flags ? 1'b0 : spurious_q;
    if (timeout_set) begin
      timeout_d = 1'b1;
    end
    if (enable && !grant_ok) begin
      spurious_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_id_q     <= '0;
      consumed_q <= 1'b0;
      wdog_q     <= '0;
      timeout_q  <= 1'b0;
      spurious_q <= 1'b0;
      for (int q = 0; q < int'(NUMBER_OF_QUEUES); q++) begin
        served_q[q] <= '0;
      end
    end else begin
      state_q    <= state_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_id_q     <= m_id_d;
      consumed_q <= consumed_d;
      wdog_q     <= wdog_d;
      timeout_q  <= timeout_d;
      spurious_q <= spurious_d;
      for (int q = 0; q < int'(NUMBER_OF_QUEUES); q++) begin
        served_q[q] <= served_d[q];
      end
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_id     = m_id_q;
  assign consumed = consumed_q;
  assign timeout  = timeout_q;
  assign spurious = spurious_q;

  for (genvar g = 0; g < int'(NUMBER_OF_QUEUES); g++) begin : g_served
    assign served[g*REGISTER_SIZE +: REGISTER_SIZE] = served_q[g];
  end

endmodule

// File: tb/tb_queue_dispatcher.sv
// Scoreboard bench for queue_dispatcher: grants push expected payloads, a negedge monitor
// checks every downstream handshake and the consumed pulse that must follow it.
module tb_queue_dispatcher;

  localparam int NQ = 4;
  localparam int DW = 64;
  localparam int RS = 32;
  localparam int TO = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic [1:0]        id;
  logic [NQ-1:0]     empty;
  logic [NQ*DW-1:0]  queue_data;
  logic [NQ-1:0]     pop;
  logic              m_valid;
  logic              m_ready;
  logic [DW-1:0]     m_data;
  logic [1:0]        m_id;
  logic              consumed;
  logic [NQ*RS-1:0]  served;
  logic              timeout;
  logic              spurious;
  logic              clear_flags;

  int total = 0;
  int bad   = 0;
  logic [DW+1:0] sb [$];
  logic [DW+1:0] exp_e;
  logic          prev_hs = 1'b0;

  always #5 clock = ~clock;

  queue_dispatcher #(
    .NUMBER_OF_QUEUES(NQ),
    .DATA_WIDTH(DW),
    .REGISTER_SIZE(RS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .id(id),
    .empty(empty),
    .queue_data(queue_data),
    .pop(pop),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_id(m_id),
    .consumed(consumed),
    .served(served),
    .timeout(timeout),
    .spurious(spurious),
    .clear_flags(clear_flags)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one grant; returns one cycle later with enable dropped.
  task automatic grant(input int q, input logic [DW-1:0] d, input bit expect_hs);
    empty = '0;
    queue_data[q*DW +: DW] = d;
    id = 2'(q);
    enable = 1'b1;
    #1;
    chk("grant_pop", 64'(pop), 64'(1) << q);
    if (expect_hs) sb.push_back({2'(q), d});
    @(posedge clock);
    #1;
    enable = 1'b0;
  endtask

  // Monitor: every handshake must match the scoreboard and be followed by consumed.
  always @(negedge clock) begin
    if (reset) begin
      prev_hs = 1'b0;
    end else begin
      if (consumed || prev_hs) chk("consumed_after_hs", 64'(consumed), 64'(prev_hs));
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_handshake", 64'(1), 64'(0));
        end else begin
          exp_e = sb.pop_front();
          chk("hs_m_data", m_data, exp_e[DW-1:0]);
          chk("hs_m_id", 64'(m_id), 64'(exp_e[DW+1:DW]));
        end
      end
      prev_hs = m_valid && m_ready;
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; id = '0; empty = '1; queue_data = '0;
    m_ready = 1'b0; clear_flags = 1'b0;
    repeat (2) step();
    reset = 1'b0;

    // Reset state
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_data", m_data, 64'(0));
    chk("rst_m_id", 64'(m_id), 64'(0));
    chk("rst_consumed", 64'(consumed), 64'(0));
    chk("rst_pop", 64'(pop), 64'(0));
    chk("rst_timeout", 64'(timeout), 64'(0));
    chk("rst_spurious", 64'(spurious), 64'(0));
    for (int q = 0; q < NQ; q++) chk("rst_served", 64'(served[q*RS +: RS]), 64'(0));

    // Basic transfer, ready held high
    m_ready = 1'b1;
    grant(2, 64'hA5, 1'b1);
    chk("t1_m_valid", 64'(m_valid), 64'(1));
    chk("t1_m_data", m_data, 64'hA5);
    chk("t1_m_id", 64'(m_id), 64'(2));
    chk("t1_pop_one_cycle", 64'(pop), 64'(0));
    step();
    chk("t1_consumed", 64'(consumed), 64'(1));
    chk("t1_m_valid_done", 64'(m_valid), 64'(0));
    step();
    chk("t1_consumed_off", 64'(consumed), 64'(0));
    chk("t1_served2", 64'(served[2*RS +: RS]), 64'(1));

    // Back-pressure for 5 cycles
    m_ready = 1'b0;
    grant(1, 64'h1111_2222_3333_4444, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 64'(m_valid), 64'(1));
      chk("t2_hold_data", m_data, 64'h1111_2222_3333_4444);
      step();
    end
    m_ready = 1'b1;
    chk("t2_valid_6th", 64'(m_valid), 64'(1));
    chk("t2_no_early_consumed", 64'(consumed), 64'(0));
    step();
    chk("t2_consumed", 64'(consumed), 64'(1));
    chk("t2_no_timeout", 64'(timeout), 64'(0));
    m_ready = 1'b0;
    step();
    chk("t2_consumed_off", 64'(consumed), 64'(0));

    // Watchdog expiry after TO stalled SEND cycles
    grant(0, 64'hBEEF, 1'b1);
    repeat (7) step();
    chk("t3_timeout_pre", 64'(timeout), 64'(0));
    step();
    chk("t3_timeout_set", 64'(timeout), 64'(1));
    chk("t3_valid_held", 64'(m_valid), 64'(1));
    step();
    m_ready = 1'b1;
    step();
    chk("t3_consumed", 64'(consumed), 64'(1));
    m_ready = 1'b0;
    step();
    chk("t3_timeout_sticky", 64'(timeout), 64'(1));
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    chk("t3_timeout_cleared", 64'(timeout), 64'(0));

    // Grant for an empty queue
    empty = 4'b1000; id = 2'd3; enable = 1'b1;
    #1;
    chk("t4_empty_no_pop", 64'(pop), 64'(0));
    step();
    enable = 1'b0;
    chk("t4_spurious", 64'(spurious), 64'(1));
    chk("t4_stay_idle", 64'(m_valid), 64'(0));
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    chk("t4_spurious_cleared", 64'(spurious), 64'(0));
    // Set wins over simultaneous clear
    empty = 4'b1000; id = 2'd3; enable = 1'b1; clear_flags = 1'b1;
    step();
    enable = 1'b0; clear_flags = 1'b0;
    chk("t4_set_wins", 64'(spurious), 64'(1));
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    // Grant while busy
    grant(1, 64'h77, 1'b1);
    id = 2'd2; enable = 1'b1;
    #1;
    chk("t4_busy_no_pop", 64'(pop), 64'(0));
    step();
    enable = 1'b0;
    chk("t4_busy_spurious", 64'(spurious), 64'(1));
    chk("t4_busy_data", m_data, 64'h77);
    chk("t4_busy_valid", 64'(m_valid), 64'(1));
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    step();
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;

    // 300 back-to-back round-robin grants at 3-cycle spacing
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      grant(i % 4, 64'(i) * 64'h1_0001 + 64'd1, 1'b1);
      step();
      step();
    end
    for (int q = 0; q < NQ; q++) chk("t5_served", 64'(served[q*RS +: RS]), 64'(75));
    chk("t5_no_spurious", 64'(spurious), 64'(0));

    // Reset during SEND drops the entry
    m_ready = 1'b0;
    grant(3, 64'h33, 1'b0);
    step();
    id = 2'd0; enable = 1'b1;
    step();
    enable = 1'b0;
    chk("t6_pre_spurious", 64'(spurious), 64'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_m_valid", 64'(m_valid), 64'(0));
    chk("t6_consumed", 64'(consumed), 64'(0));
    chk("t6_spurious", 64'(spurious), 64'(0));
    chk("t6_timeout", 64'(timeout), 64'(0));
    for (int q = 0; q < NQ; q++) chk("t6_served", 64'(served[q*RS +: RS]), 64'(0));
    step();
    chk("t6_no_consumed_after", 64'(consumed), 64'(0));
    chk("t6_idle", 64'(m_valid), 64'(0));

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
